// File: rtl/micro_port_rx.sv
// Micro-port receiver: synchronises an asynchronous 8-bit micro bus into shadow
// registers and copies them to the active set at vertical blank.
// Optional MICRO_PORT_RX_AUTOINC_EN: each accepted data write increments addr.
module micro_port_rx #(
    parameter int NUM_REGS = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] fpga_port_in,
    input  logic       fpga_rsel,
    input  logic       fpga_write,
    input  logic       frame_start,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       commit_pending,
    output logic       addr_err,
    output logic       wr_pulse
);

    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [7:0] CMD_COMMIT = 8'hFF;
    localparam logic [7:0] CMD_CLEAR  = 8'hFE;

    // Synchroniser stages for the asynchronous micro bus
    logic [7:0] data_s1_reg;
    logic [7:0] data_s2_reg;
    logic       rsel_s1_reg;
    logic       rsel_s2_reg;
    logic       wr_s1_reg;
    logic       wr_s2_reg;
    logic       wr_s3_reg;

    // Track when wr_s2_reg reflects the pin again after reset, so that a strobe
    // already high at release is ignored until it has been seen low.
    logic       fill_s1_reg;
    logic       fill_s2_reg;
    logic       armed_reg;

    logic [7:0] addr_reg;
    logic       addr_valid_reg;
    logic       commit_pending_reg;
    logic       addr_err_reg;
    logic       wr_pulse_reg;

    logic       event_w;
    logic       cmd_commit_w;
    logic       cmd_clear_w;
    logic       cmd_addr_w;
    logic       data_ev_w;
    logic       shadow_we_w;
    logic       copy_en_w;
    logic       addr_in_range_w;

    logic [NUM_REGS-1:0][7:0] active_flat;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            data_s1_reg <= '0;
            data_s2_reg <= '0;
            rsel_s1_reg <= 1'b0;
            rsel_s2_reg <= 1'b0;
            wr_s1_reg   <= 1'b0;
            wr_s2_reg   <= 1'b0;
            wr_s3_reg   <= 1'b0;
            fill_s1_reg <= 1'b0;
            fill_s2_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            data_s1_reg <= fpga_port_in;
            data_s2_reg <= data_s1_reg;
            rsel_s1_reg <= fpga_rsel;
            rsel_s2_reg <= rsel_s1_reg;
            wr_s1_reg   <= fpga_write;
            wr_s2_reg   <= wr_s1_reg;
            wr_s3_reg   <= wr_s2_reg;
            fill_s1_reg <= 1'b1;
            fill_s2_reg <= fill_s1_reg;
            armed_reg   <= armed_reg | (fill_s2_reg & ~wr_s2_reg);
        end
    end

    always_comb begin
        event_w         = armed_reg & wr_s2_reg & ~wr_s3_reg;
        cmd_commit_w    = event_w & rsel_s2_reg & (data_s2_reg == CMD_COMMIT);
        cmd_clear_w     = event_w & rsel_s2_reg & (data_s2_reg == CMD_CLEAR);
        cmd_addr_w      = event_w & rsel_s2_reg & ~cmd_commit_w & ~cmd_clear_w;
        data_ev_w       = event_w & ~rsel_s2_reg;
        shadow_we_w     = data_ev_w & addr_valid_reg;
        copy_en_w       = frame_start & commit_pending_reg;
        addr_in_range_w = ({1'b0, data_s2_reg} < NUM_REGS_W);
    end

`ifdef MICRO_PORT_RX_AUTOINC_EN
    logic [8:0] addr_inc_w;
    assign addr_inc_w = {1'b0, addr_reg} + 9'd1;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_reg       <= '0;
            addr_valid_reg <= 1'b1;
        end else if (cmd_addr_w) begin
            addr_reg       <= data_s2_reg;
            addr_valid_reg <= addr_in_range_w;
        end
`ifdef MICRO_PORT_RX_AUTOINC_EN
        // Running off the end invalidates addr without wrapping or flagging
        else if (shadow_we_w) begin
            addr_reg       <= addr_inc_w[7:0];
            addr_valid_reg <= (addr_inc_w < NUM_REGS_W);
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            commit_pending_reg <= 1'b0;
            addr_err_reg       <= 1'b0;
            wr_pulse_reg       <= 1'b0;
        end else begin
            // A new commit request wins over the copy that consumes the old one
            if (cmd_commit_w) begin
                commit_pending_reg <= 1'b1;
            end else if (copy_en_w) begin
                commit_pending_reg <= 1'b0;
            end

            if (cmd_clear_w) begin
                addr_err_reg <= 1'b0;
            end else if ((cmd_addr_w && !addr_in_range_w) || (data_ev_w && !addr_valid_reg)) begin
                addr_err_reg <= 1'b1;
            end

            wr_pulse_reg <= shadow_we_w;
        end
    end

    // Active copies take the shadow value held before any same-cycle write
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [7:0] shadow_reg;
        logic [7:0] active_reg;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                shadow_reg <= '0;
                active_reg <= '0;
            end else begin
                if (shadow_we_w && (addr_reg == 8'(gi))) begin
                    shadow_reg <= data_s2_reg;
                end
                if (copy_en_w) begin
                    active_reg <= shadow_reg;
                end
            end
        end

        assign active_flat[gi] = active_reg;
    end

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 8'(i)) begin
                rd_data = active_flat[i];
            end
        end
    end

    assign commit_pending = commit_pending_reg;
    assign addr_err       = addr_err_reg;
    assign wr_pulse       = wr_pulse_reg;

endmodule

// File: tb/tb_micro_port_rx.sv
// Randomised self-checking bench for micro_port_rx against a register-level
// behavioural model of the micro command protocol.
`timescale 1ns/1ps
module tb_micro_port_rx;

    localparam int NUM_REGS = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] fpga_port_in = '0;
    logic       fpga_rsel = 1'b0;
    logic       fpga_write = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       commit_pending;
    logic       addr_err;
    logic       wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    // Behavioural model state
    logic [7:0] m_shadow [NUM_REGS];
    logic [7:0] m_active [NUM_REGS];
    int         m_addr;
    bit         m_valid;
    bit         m_pending;
    bit         m_err;
    int         m_pulses = 0;

    micro_port_rx #(.NUM_REGS(NUM_REGS)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .fpga_port_in   (fpga_port_in),
        .fpga_rsel      (fpga_rsel),
        .fpga_write     (fpga_write),
        .frame_start    (frame_start),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .commit_pending (commit_pending),
        .addr_err       (addr_err),
        .wr_pulse       (wr_pulse)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_addr = 0; m_valid = 1; m_pending = 0; m_err = 0;
    endtask

    task automatic m_frame();
        if (m_pending) begin
            for (int i = 0; i < NUM_REGS; i++) m_active[i] = m_shadow[i];
            m_pending = 0;
        end
    endtask

    task automatic m_write(input bit rs, input logic [7:0] b);
        if (rs) begin
            if (b == 8'hFF) m_pending = 1;
            else if (b == 8'hFE) m_err = 0;
            else begin
                m_addr  = int'(b);
                m_valid = (m_addr < NUM_REGS);
                if (!m_valid) m_err = 1;
            end
        end else if (m_valid) begin
            m_shadow[m_addr] = b;
            m_pulses++;
`ifdef MICRO_PORT_RX_AUTOINC_EN
            m_addr  = m_addr + 1;
            m_valid = (m_addr < NUM_REGS);
`endif
        end else begin
            m_err = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        rd_addr = 8'd0;
        #1;
        check_val("rst_pending", commit_pending, 0);
        check_val("rst_err", addr_err, 0);
        check_val("rst_pulse", wr_pulse, 0);
        check_val("rst_rd0", rd_data, 0);
        @(negedge Clk);
        Reset = 1'b1;
        m_reset();
        $display("reset applied");
    endtask

    // One micro write cycle; co=1 lines frame_start up with the event cycle
    task automatic micro_write(input bit rs, input logic [7:0] b, input bit co);
        @(negedge Clk);
        fpga_port_in = b;
        fpga_rsel    = rs;
        @(negedge Clk);
        fpga_write = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        if (co) frame_start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        frame_start = 1'b0;
        if (co) m_frame();
        m_write(rs, b);
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        fpga_write = 1'b0;
        repeat (4) @(negedge Clk);
        $display("write rsel=%0d byte=0x%02h coincident=%0d", rs, b, co);
    endtask

    task automatic do_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        m_frame();
        $display("frame_start pulse");
    endtask

    task automatic read_reg(input int idx, output logic [7:0] val);
        rd_addr = 8'(idx);
        #1;
        val = rd_data;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        check_val({tag, "_pending"}, commit_pending, m_pending);
        check_val({tag, "_err"}, addr_err, m_err);
        check_val({tag, "_pulses"}, pulse_cnt, m_pulses);
        for (int i = 0; i < NUM_REGS + 2; i++) begin
            read_reg(i, v);
            e = (i < NUM_REGS) ? m_active[i] : 8'h00;
            check_val($sformatf("%s_rd%0d", tag, i), v, e);
        end
        read_reg(255, v);
        check_val({tag, "_rd255"}, v, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] b;
        int r;
        m_reset();
        do_reset();
        check_state("reset");

        // Basic write, commit, copy
        micro_write(1, 8'h03, 0);
        micro_write(0, 8'h5A, 0);
        micro_write(1, 8'hFF, 0);
        check_val("basic_pending_set", commit_pending, 1);
        do_frame();
        read_reg(3, v);
        check_val("basic_rd3", v, 8'h5A);
        check_state("basic");

        // No commit: active stays clear
        do_reset();
        micro_write(0, 8'h11, 0);
        do_frame();
        read_reg(0, v);
        check_val("nocommit_rd0", v, 8'h00);
        check_state("nocommit");

        // Out-of-range address
        do_reset();
        micro_write(1, 8'h20, 0);
        micro_write(0, 8'h77, 0);
        check_val("badaddr_err", addr_err, 1);
        micro_write(1, 8'hFF, 0);
        do_frame();
        check_state("badaddr");
        micro_write(1, 8'hFE, 0);
        check_val("badaddr_clear", addr_err, 0);

        // Writes near the top of the register file
        do_reset();
        micro_write(1, 8'h0E, 0);
        micro_write(0, 8'hA1, 0);
        micro_write(0, 8'hA2, 0);
        micro_write(0, 8'hA3, 0);
        micro_write(1, 8'hFF, 0);
        do_frame();
        read_reg(14, v);
`ifdef MICRO_PORT_RX_AUTOINC_EN
        check_val("top_rd14", v, 8'hA1);
        read_reg(15, v);
        check_val("top_rd15", v, 8'hA2);
        check_val("top_err", addr_err, 1);
`else
        check_val("top_rd14", v, 8'hA3);
`endif
        check_state("top");

        // Commit command coincident with frame_start
        do_reset();
        micro_write(1, 8'h02, 0);
        micro_write(0, 8'hC3, 0);
        micro_write(1, 8'hFF, 1);
        check_val("coin_pending", commit_pending, 1);
        read_reg(2, v);
        check_val("coin_nocopy", v, 8'h00);
        do_frame();
        read_reg(2, v);
        check_val("coin_copy", v, 8'hC3);
        check_state("coin");

        // Strobe held high across a reset pulse
        do_reset();
        @(negedge Clk);
        fpga_port_in = 8'h3C;
        fpga_rsel    = 1'b0;
        @(negedge Clk);
        fpga_write = 1'b1;
        repeat (10) @(negedge Clk);
        m_write(0, 8'h3C);
        check_val("held_one_event", pulse_cnt, m_pulses);
        repeat (10) @(negedge Clk);
        do_reset();
        repeat (30) @(negedge Clk);
        check_state("held_after_rst");
        fpga_write = 1'b0;
        repeat (4) @(negedge Clk);
        micro_write(0, 8'h3C, 0);
        micro_write(1, 8'hFF, 0);
        do_frame();
        check_state("held_rearm");

        // Randomised command mix
        do_reset();
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else b = 8'($urandom_range(0, NUM_REGS + 3));
            if (r < 35)      micro_write(0, 8'($urandom), 0);
            else if (r < 58) micro_write(1, b, 0);
            else if (r < 70) micro_write(1, 8'hFF, 0);
            else if (r < 76) micro_write(1, 8'hFE, 0);
            else if (r < 88) do_frame();
            else if (r < 94) micro_write(1, 8'hFF, 1);
            else             micro_write(0, 8'($urandom), 1);
            check_state($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_port_rx.md
MICRO_PORT_RX -- requirements
Module: micro_port_rx

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit sprite/config registers (2..254).
REQ-002 SHALL have port Clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fpga_port_in  input  8  micro data byte, asynchronous to Clk.
REQ-005 SHALL have port fpga_rsel  input  1  micro register-select: 1 = address/command byte, 0 = data byte; asynchronous.
REQ-006 SHALL have port fpga_write  input  1  micro write strobe, rising-edge active; asynchronous.
REQ-007 SHALL have port frame_start  input  1  one-Clk pulse from the display timing at start of vertical blank.
REQ-008 SHALL have port rd_addr  input  8  active-register read index from the sprite logic.
REQ-009 SHALL have port rd_data  output  8  active-register read data.
REQ-010 SHALL have port commit_pending  output  1  shadow-to-active copy is armed.
REQ-011 SHALL have port addr_err  output  1  sticky error flag.
REQ-012 SHALL have port wr_pulse  output  1  one-Clk pulse per accepted shadow data write.

Function
REQ-013 SHALL pass fpga_port_in, fpga_rsel and fpga_write each through two flops; fpga_write gets a third flop for edge detection.
REQ-014 SHALL act on a micro write only in the cycle where synced write = 1 and the delayed copy = 0 (event cycle); data and rsel are taken from the synced stages in that cycle.
REQ-015 SHALL reach the event cycle on the third Clk edge after the pin edge is first sampled; a strobe held high produces exactly one event.
REQ-016 Event with rsel=1 and byte 0xFF SHALL set commit_pending; addr unchanged.
REQ-017 Event with rsel=1 and byte 0xFE SHALL clear addr_err; addr unchanged.
REQ-018 Event with rsel=1 and any other byte SHALL load addr; a byte >= NUM_REGS SHALL make addr invalid and set addr_err.
REQ-019 Event with rsel=0 and addr valid SHALL write shadow[addr] and pulse wr_pulse the following cycle.
REQ-020 Event with rsel=0 and addr invalid SHALL leave shadow unchanged, suppress wr_pulse and set addr_err.
REQ-021 On frame_start with commit_pending=1, SHALL copy all shadow registers to active in one cycle and clear commit_pending.
REQ-022 On frame_start with commit_pending=0, active SHALL be unchanged.
REQ-023 If a 0xFF event and frame_start coincide, copy SHALL follow the pre-cycle pending value and commit_pending SHALL be 1 afterwards.
REQ-024 If a shadow write and a copy coincide, active SHALL receive the pre-write shadow value.
REQ-025 rd_data SHALL be combinational active[rd_addr]; 0x00 when rd_addr >= NUM_REGS.

Reset
REQ-026 While Reset=0, all synchronizer flops, shadow, active, addr SHALL be 0; commit_pending, addr_err and wr_pulse SHALL be 0; addr valid.
REQ-027 A write event in progress at reset assertion SHALL be discarded; after release a strobe already high SHALL NOT produce an event until it falls and rises again.

Configuration
REQ-028 With MICRO_PORT_RX_AUTOINC_EN defined, each accepted data write SHALL increment addr; an increment reaching NUM_REGS SHALL make addr invalid without wrapping and without setting addr_err.
REQ-029 Without MICRO_PORT_RX_AUTOINC_EN, addr SHALL hold its value across data writes.

Verification
REQ-030 Reset, addr 0x03, data 0x5A, 0xFF, frame_start -> rd_addr 3 gives 0x5A; commit_pending 1 then 0; wr_pulse exactly once.
REQ-031 Data 0x11 without commit, frame_start -> rd_data remains 0x00; commit_pending 0.
REQ-032 Addr 0x20 (NUM_REGS=16), data 0x77 -> addr_err 1, no wr_pulse, shadow unchanged; 0xFE -> addr_err 0.
REQ-033 AUTOINC_EN: addr 0x0E, data 0xA1,0xA2,0xA3 -> regs 14,15 = 0xA1,0xA2; third write ignored, addr_err 1; without macro reg 14 = 0xA3.
REQ-034 0xFF event coincident with frame_start, pending 0 -> no copy that cycle; pending 1; next frame_start copies.
REQ-035 fpga_write held high 50 cycles; Reset pulsed low mid-strobe -> one event before reset, none after release until a new rising edge.
